// File: rtl/side_speed_pkg.sv
// rtl/side_speed_pkg.sv - Shared encodings and field widths for the side-wheel speed sequencer
package side_speed_pkg;

    localparam int DIR_BIT = 7;
    localparam int MAG_W   = 7;
    localparam int CMD_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RAMP  = 2'd1,
        ST_BRAKE = 2'd2,
        ST_HOLD  = 2'd3
    } seq_state_t;

    typedef logic [MAG_W-1:0] mag_t;

    function automatic mag_t clamp_mag(input mag_t m, input mag_t lim);
        return (m > lim) ? lim : m;
    endfunction

endpackage

// File: rtl/side_speed_sequencer_if.sv
// rtl/side_speed_sequencer_if.sv - Command handshake bundle for requesters A (remote) and B (avoidance)
interface side_speed_sequencer_if;

    logic                           cmd_valid_a;
    logic [side_speed_pkg::CMD_W-1:0] cmd_a;
    logic                           cmd_ready_a;
    logic                           cmd_valid_b;
    logic [side_speed_pkg::CMD_W-1:0] cmd_b;
    logic                           cmd_ready_b;

    modport master (
        output cmd_valid_a, cmd_a, cmd_valid_b, cmd_b,
        input  cmd_ready_a, cmd_ready_b
    );

    modport slave (
        input  cmd_valid_a, cmd_a, cmd_valid_b, cmd_b,
        output cmd_ready_a, cmd_ready_b
    );

endinterface

// File: rtl/ramp_tick_gen.sv
// rtl/ramp_tick_gen.sv - Free-running divider producing a one-cycle ramp tick every DIV cycles
module ramp_tick_gen #(
    parameter int DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int            CW   = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/side_speed_sequencer.sv
// rtl/side_speed_sequencer.sv - Two-requester side-wheel speed sequencer with ramp, brake and timeout
module side_speed_sequencer
    import side_speed_pkg::*;
#(
    parameter int STEP_DIV      = 50000,
    parameter int STEP          = 1,
    parameter int MAX_MAG       = 100,
    parameter int TIMEOUT_TICKS = 250
) (
    input  logic                  clk,
    input  logic                  rst_n,
    side_speed_sequencer_if.slave cmd_if,
    output logic [CMD_W-1:0]      side_speed,
    output logic [1:0]            state,
    output logic                  at_target
);

    localparam mag_t            STEP_M  = mag_t'(STEP);
    localparam mag_t            MAX_M   = mag_t'(MAX_MAG);
    localparam int              TO_W    = (TIMEOUT_TICKS > 0) ? $clog2(TIMEOUT_TICKS + 1) : 1;
    localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT_TICKS);
    localparam logic [TO_W-1:0] TO_FIRE = TO_W'((TIMEOUT_TICKS > 0) ? TIMEOUT_TICKS - 1 : 0);

    logic             tick;
    logic             acc_a;
    logic             acc_b;
    logic             acc;
    logic [CMD_W-1:0] acc_cmd;
    logic             timeout_fire;
    logic [TO_W-1:0]  to_cnt;
    mag_t             tgt_mag;
    logic             tgt_dir;
    mag_t             cur_mag;
    logic             cur_dir;
    mag_t             mag_nxt;
    logic             dir_nxt;
    seq_state_t       state_q;
    seq_state_t       state_nxt;
    logic             at_target_nxt;

    ramp_tick_gen #(
        .DIV (STEP_DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // B has strict priority; A is only offered the port while B is silent.
    assign cmd_if.cmd_ready_b = 1'b1;
    assign cmd_if.cmd_ready_a = !cmd_if.cmd_valid_b;
    assign acc_b   = cmd_if.cmd_valid_b;
    assign acc_a   = cmd_if.cmd_valid_a && !cmd_if.cmd_valid_b;
    assign acc     = acc_a || acc_b;
    assign acc_cmd = acc_b ? cmd_if.cmd_b : cmd_if.cmd_a;

    assign timeout_fire = (TIMEOUT_TICKS != 0) && tick && !acc && (to_cnt == TO_FIRE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (acc) begin
            to_cnt <= '0;
        end else if (tick && (to_cnt != TO_MAX)) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // A timeout parks the target at zero in the current direction so the stop is a plain ramp-down.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tgt_mag <= '0;
            tgt_dir <= 1'b0;
        end else if (acc) begin
            tgt_mag <= clamp_mag(acc_cmd[MAG_W-1:0], MAX_M);
            tgt_dir <= acc_cmd[DIR_BIT];
        end else if (timeout_fire) begin
            tgt_mag <= '0;
            tgt_dir <= cur_dir;
        end
    end

    always_comb begin
        mag_nxt = cur_mag;
        dir_nxt = cur_dir;
        if (cur_mag == '0) begin
            dir_nxt = tgt_dir;
        end
        if (tick) begin
            if ((tgt_dir != cur_dir) && (cur_mag != '0)) begin
                mag_nxt = (cur_mag > STEP_M) ? cur_mag - STEP_M : '0;
                if (mag_nxt == '0) begin
                    dir_nxt = tgt_dir;
                end
            end else if (cur_mag < tgt_mag) begin
                mag_nxt = ((tgt_mag - cur_mag) > STEP_M) ? cur_mag + STEP_M : tgt_mag;
            end else if (cur_mag > tgt_mag) begin
                mag_nxt = ((cur_mag - tgt_mag) > STEP_M) ? cur_mag - STEP_M : tgt_mag;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_mag <= '0;
            cur_dir <= 1'b0;
        end else begin
            cur_mag <= mag_nxt;
            cur_dir <= dir_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            at_target <= 1'b1;
        end else begin
            state_q   <= state_nxt;
            at_target <= at_target_nxt;
        end
    end

    // State is classified from the post-update output against the target it was stepped toward.
    always_comb begin
        state_nxt = ST_RAMP;
        if (dir_nxt != tgt_dir) begin
            state_nxt = ST_BRAKE;
        end else if (mag_nxt == tgt_mag) begin
            state_nxt = (tgt_mag == '0) ? ST_IDLE : ST_HOLD;
        end
    end

    always_comb begin
        at_target_nxt = (state_nxt == ST_IDLE) || (state_nxt == ST_HOLD);
    end

    assign side_speed = {cur_dir, cur_mag};
    assign state      = state_q;

endmodule

// File: tb/tb_side_speed_sequencer.sv
// tb/tb_side_speed_sequencer.sv - Scoreboard bench for side_speed_sequencer ramp, brake, priority and timeout
module tb_side_speed_sequencer;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RAMP  = 2'd1;
    localparam logic [1:0] S_BRAKE = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] side_speed;
    logic [1:0] state;
    logic       at_target;
    logic [1:0] bcnt;
    logic [9:0] exp_q[$];
    int         n_checks = 0;
    int         n_fail = 0;

    side_speed_sequencer_if bus();

    side_speed_sequencer #(
        .STEP_DIV      (4),
        .STEP          (10),
        .MAX_MAG       (100),
        .TIMEOUT_TICKS (5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_if     (bus),
        .side_speed (side_speed),
        .state      (state),
        .at_target  (at_target)
    );

    always #5 clk = ~clk;

    // Cycle position since reset release; the edge after bcnt==3 is a ramp tick edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) bcnt <= 2'd0;
        else        bcnt <= bcnt + 2'd1;
    end

    task automatic wait_tick();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 16 && !seen; i++) begin
            @(negedge clk);
            if (bcnt == 2'd3) begin
                @(posedge clk);
                #1;
                seen = 1'b1;
            end
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL tick_wait: no tick edge within 16 cycles");
        end
    endtask

    task automatic send_cmd(input bit is_b, input logic [7:0] c);
        @(negedge clk);
        if (is_b) begin
            bus.cmd_b       = c;
            bus.cmd_valid_b = 1'b1;
        end else begin
            bus.cmd_a       = c;
            bus.cmd_valid_a = 1'b1;
        end
        @(posedge clk);
        #1;
        bus.cmd_valid_a = 1'b0;
        bus.cmd_valid_b = 1'b0;
    endtask

    task automatic test_reset();
        rst_n           = 1'b0;
        bus.cmd_valid_a = 1'b0;
        bus.cmd_valid_b = 1'b0;
        bus.cmd_a       = 8'h00;
        bus.cmd_b       = 8'h00;
        repeat (3) @(negedge clk);
        n_checks++; if (side_speed !== 8'h00) begin n_fail++; $display("FAIL reset side_speed: got %h expected 00", side_speed); end
        n_checks++; if (state !== S_IDLE) begin n_fail++; $display("FAIL reset state: got %0d expected 0", state); end
        n_checks++; if (at_target !== 1'b1) begin n_fail++; $display("FAIL reset at_target: got %b expected 1", at_target); end
        n_checks++; if (bus.cmd_ready_b !== 1'b1) begin n_fail++; $display("FAIL reset cmd_ready_b: got %b expected 1", bus.cmd_ready_b); end
        n_checks++; if (bus.cmd_ready_a !== 1'b1) begin n_fail++; $display("FAIL reset cmd_ready_a: got %b expected 1", bus.cmd_ready_a); end
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        n_checks++; if (side_speed !== 8'h00) begin n_fail++; $display("FAIL idle_after_reset side_speed: got %h expected 00", side_speed); end
    endtask

    task automatic test_ramp_up();
        logic [9:0] e;
        send_cmd(1'b0, 8'h32);
        for (int m = 10; m <= 50; m += 10) exp_q.push_back({(m == 50) ? S_HOLD : S_RAMP, 8'(m)});
        while (exp_q.size() > 0) begin
            wait_tick();
            e = exp_q.pop_front();
            n_checks++; if (side_speed !== e[7:0]) begin n_fail++; $display("FAIL ramp_up side_speed: got %h expected %h", side_speed, e[7:0]); end
            n_checks++; if (state !== e[9:8]) begin n_fail++; $display("FAIL ramp_up state: got %0d expected %0d", state, e[9:8]); end
            n_checks++; if (at_target !== (e[9:8] == S_HOLD)) begin n_fail++; $display("FAIL ramp_up at_target: got %b at speed %h", at_target, e[7:0]); end
            send_cmd(1'b0, 8'h32);
        end
    endtask

    task automatic test_reverse();
        logic [9:0] e;
        send_cmd(1'b1, 8'h9E);
        for (int m = 40; m >= 10; m -= 10) exp_q.push_back({S_BRAKE, 8'(m)});
        exp_q.push_back({S_RAMP, 8'h80});
        exp_q.push_back({S_RAMP, 8'h8A});
        exp_q.push_back({S_RAMP, 8'h94});
        exp_q.push_back({S_HOLD, 8'h9E});
        while (exp_q.size() > 0) begin
            wait_tick();
            e = exp_q.pop_front();
            n_checks++; if (side_speed !== e[7:0]) begin n_fail++; $display("FAIL reverse side_speed: got %h expected %h", side_speed, e[7:0]); end
            n_checks++; if (state !== e[9:8]) begin n_fail++; $display("FAIL reverse state: got %0d expected %0d", state, e[9:8]); end
            send_cmd(1'b1, 8'h9E);
        end
        n_checks++; if (at_target !== 1'b1) begin n_fail++; $display("FAIL reverse at_target: got %b expected 1", at_target); end
    endtask

    task automatic test_priority();
        logic [9:0] e;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        bus.cmd_a = 8'h14; bus.cmd_valid_a = 1'b1;
        bus.cmd_b = 8'h28; bus.cmd_valid_b = 1'b1;
        #1;
        n_checks++; if (bus.cmd_ready_a !== 1'b0) begin n_fail++; $display("FAIL priority cmd_ready_a: got %b expected 0", bus.cmd_ready_a); end
        n_checks++; if (bus.cmd_ready_b !== 1'b1) begin n_fail++; $display("FAIL priority cmd_ready_b: got %b expected 1", bus.cmd_ready_b); end
        for (int m = 10; m <= 30; m += 10) exp_q.push_back({S_RAMP, 8'(m)});
        while (exp_q.size() > 0) begin
            wait_tick();
            e = exp_q.pop_front();
            n_checks++; if (side_speed !== e[7:0]) begin n_fail++; $display("FAIL priority_b side_speed: got %h expected %h", side_speed, e[7:0]); end
            n_checks++; if (bus.cmd_ready_a !== 1'b0) begin n_fail++; $display("FAIL priority_stall cmd_ready_a: got %b expected 0", bus.cmd_ready_a); end
        end
        @(negedge clk);
        bus.cmd_valid_b = 1'b0;
        #1;
        n_checks++; if (bus.cmd_ready_a !== 1'b1) begin n_fail++; $display("FAIL priority_release cmd_ready_a: got %b expected 1", bus.cmd_ready_a); end
        @(posedge clk);
        #1;
        bus.cmd_valid_a = 1'b0;
        exp_q.push_back({S_HOLD, 8'h14});
        wait_tick();
        e = exp_q.pop_front();
        n_checks++; if (side_speed !== e[7:0]) begin n_fail++; $display("FAIL priority_a side_speed: got %h expected %h", side_speed, e[7:0]); end
        n_checks++; if (state !== e[9:8]) begin n_fail++; $display("FAIL priority_a state: got %0d expected %0d", state, e[9:8]); end
    endtask

    task automatic test_clamp();
        logic [9:0] e;
        send_cmd(1'b0, 8'h7F);
        for (int m = 30; m <= 100; m += 10) exp_q.push_back({(m == 100) ? S_HOLD : S_RAMP, 8'(m)});
        while (exp_q.size() > 0) begin
            wait_tick();
            e = exp_q.pop_front();
            n_checks++; if (side_speed !== e[7:0]) begin n_fail++; $display("FAIL clamp side_speed: got %h expected %h", side_speed, e[7:0]); end
            n_checks++; if (state !== e[9:8]) begin n_fail++; $display("FAIL clamp state: got %0d expected %0d", state, e[9:8]); end
            send_cmd(1'b0, 8'h7F);
        end
        send_cmd(1'b0, 8'h37);
        for (int m = 90; m >= 60; m -= 10) exp_q.push_back({S_RAMP, 8'(m)});
        exp_q.push_back({S_HOLD, 8'h37});
        while (exp_q.size() > 0) begin
            wait_tick();
            e = exp_q.pop_front();
            n_checks++; if (side_speed !== e[7:0]) begin n_fail++; $display("FAIL no_overshoot side_speed: got %h expected %h", side_speed, e[7:0]); end
            n_checks++; if (state !== e[9:8]) begin n_fail++; $display("FAIL no_overshoot state: got %0d expected %0d", state, e[9:8]); end
            send_cmd(1'b0, 8'h37);
        end
    endtask

    task automatic test_timeout();
        logic [9:0] e;
        send_cmd(1'b0, 8'h32);
        for (int k = 0; k < 5; k++) exp_q.push_back({S_HOLD, 8'h32});
        for (int m = 40; m >= 10; m -= 10) exp_q.push_back({S_RAMP, 8'(m)});
        exp_q.push_back({S_IDLE, 8'h00});
        while (exp_q.size() > 0) begin
            wait_tick();
            e = exp_q.pop_front();
            n_checks++; if (side_speed !== e[7:0]) begin n_fail++; $display("FAIL timeout side_speed: got %h expected %h", side_speed, e[7:0]); end
            n_checks++; if (state !== e[9:8]) begin n_fail++; $display("FAIL timeout state: got %0d expected %0d", state, e[9:8]); end
        end
        n_checks++; if (at_target !== 1'b1) begin n_fail++; $display("FAIL timeout at_target: got %b expected 1", at_target); end
    endtask

    task automatic test_reset_mid_ramp();
        logic [9:0] e;
        send_cmd(1'b0, 8'h32);
        exp_q.push_back({S_RAMP, 8'h0A});
        exp_q.push_back({S_RAMP, 8'h14});
        while (exp_q.size() > 0) begin
            wait_tick();
            e = exp_q.pop_front();
            n_checks++; if (side_speed !== e[7:0]) begin n_fail++; $display("FAIL pre_reset side_speed: got %h expected %h", side_speed, e[7:0]); end
            send_cmd(1'b0, 8'h32);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++; if (side_speed !== 8'h00) begin n_fail++; $display("FAIL async_reset side_speed: got %h expected 00", side_speed); end
        n_checks++; if (state !== S_IDLE) begin n_fail++; $display("FAIL async_reset state: got %0d expected 0", state); end
        n_checks++; if (at_target !== 1'b1) begin n_fail++; $display("FAIL async_reset at_target: got %b expected 1", at_target); end
        bus.cmd_a       = 8'h32;
        bus.cmd_valid_a = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid_a = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        n_checks++; if (side_speed !== 8'h00) begin n_fail++; $display("FAIL first_tick_early side_speed: got %h expected 00 after 3 cycles", side_speed); end
        @(posedge clk); #1;
        n_checks++; if (side_speed !== 8'h0A) begin n_fail++; $display("FAIL first_tick side_speed: got %h expected 0a after 4 cycles", side_speed); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_ramp_up();
        test_reverse();
        test_priority();
        test_clamp();
        test_timeout();
        test_reset_mid_ramp();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
